ahb_lite_fifo_master: RTL and testbench
=======================================

// Module: ahb_lite_fifo_master
// PURPOSE
//  Downstream stage of the transaction FIFO. Pops queued transfers {write, size, addr, data} and drives them on AHB-Lite as pipelined SINGLE transfers.
//  Returns one response per popped command, in pop order: read data or write ack, plus an error flag.
//  Full address/data-phase pipelining: 1 transfer/cycle with zero wait states.
// PARAMETERS
//  BUS_WIDTH  32  width of address and data buses (matches `BUS_WIDTH)
// PORTS
//  clk        in   1          clock, all state on rising edge
//  resetn     in   1          asynchronous active-low reset
//  cmd_valid  in   1          FIFO not empty / command present
//  cmd_ready  out  1          pop strobe: command consumed when cmd_valid&&cmd_ready at posedge
//  cmd_write  in   1          1=write, 0=read
//  cmd_size   in   3          HSIZE encoding
//  cmd_addr   in   BUS_WIDTH  transfer address, size-aligned (upstream guarantee, not checked)
//  cmd_wdata  in   BUS_WIDTH  write data, already on correct byte lanes
//  rsp_valid  out  1          1-cycle response pulse, no backpressure
//  rsp_write  out  1          direction of responded transfer
//  rsp_error  out  1          transfer got ERROR or was cancelled
//  rsp_rdata  out  BUS_WIDTH  read data (0 for writes/errors)
//  HADDR      out  BUS_WIDTH  AHB address
//  HWRITE     out  1          AHB direction
//  HSIZE      out  3          AHB size
//  HBURST     out  3          constant 3'b000 (SINGLE)
//  HPROT      out  4          constant 4'b0011
//  HMASTLOCK  out  1          constant 0
//  HTRANS     out  2          IDLE=2'b00 / NONSEQ=2'b10 only
//  HWDATA     out  BUS_WIDTH  write data, data phase
//  HRDATA     in   BUS_WIDTH  read data
//  HREADY     in   1          transfer done / bus ready
//  HRESP      in   1          0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: HTRANS=IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0; rsp_* = 0; cmd_ready=0 while resetn low.
//  Internal state:
//    AP slot = transfer in address phase; visible on HADDR/HWRITE/HSIZE/HTRANS.
//    DP slot = {valid, write, wdata} of transfer in data phase.
//    err_st  = NONE / ERR1 / ERR2.
//    cancel_pend flag.
//  cmd_ready = HREADY && err_st==NONE && !cancel_pend.
//  Edge with HREADY=1, err NONE:
//    AP moves to DP.
//    Accepted cmd (if any) loads AP with HTRANS=NONSEQ; otherwise HTRANS<=IDLE.
//  Edge with HREADY=0: AP and DP hold; AP address/control stays stable.
//  HWDATA = DP.wdata when DP is a write; otherwise holds its last value.
//  Completion is an edge with DP valid and HREADY=1 (OKAY or ERROR).
//    Next cycle: rsp_valid=1.
//    rsp_rdata = HRDATA sampled at completion (reads only, OKAY only; else 0).
//    rsp_error = HRESP.
//  Latency: accept at edge N -> NONSEQ in cycle N+1 -> data phase N+2 -> rsp_valid in N+3 (zero waits).
//  Error handling (two-cycle ERROR response):
//    Edge sampling DP valid, HRESP=1, HREADY=0 enters ERR1. HTRANS<=IDLE in the 2nd error cycle.
//    If AP held a NONSEQ, that transfer is cancelled (never issued) and cancel_pend=1.
//    Edge sampling HRESP=1, HREADY=1: errored response issued, then back to NONE.
//    If cancel_pend: the next cycle emits the cancelled transfer's response (rsp_error=1), then clears cancel_pend.
//    Order is always preserved. No cmd accepted from the ERR1 edge until cancel_pend clears.
//  Invariants:
//    Exactly one response per accepted cmd, in order.
//    Never two rsp in one cycle.
//    HTRANS never BUSY/SEQ.
//  Reset mid-transfer: all slots dropped, no responses for in-flight cmds, outputs return to reset values immediately.
// TESTING
//  1 Reset: resetn=0 -> HTRANS=00, cmd_ready=0, rsp_valid=0; release with HREADY=1 -> cmd_ready=1.
//  2 Back-to-back: 3 cmds (W 0x10/0xAA, R 0x14, W 0x18/0xCC), HREADY=1, HRDATA=0x55 -> NONSEQ 3 consecutive cycles.
//    HWDATA 0xAA,-,0xCC one cycle behind addresses; rsp W/ok, R/0x55, W/ok at N+3..N+5.
//  3 Wait states: read 0x20, HREADY=0 for 2 cycles in data phase -> next HADDR held stable, cmd_ready=0.
//    rsp_valid only after HREADY=1.
//  4 Error+cancel: W 0x30 then R 0x34, slave ERROR on 0x30 -> cycle2 HTRANS=IDLE, 0x34 never issued.
//    rsp W/err then R/err on consecutive cycles.
//  5 Empty FIFO: cmd_valid=0 -> HTRANS stays IDLE, no rsp.
//  6 Async reset mid data phase: resetn=0 while waited read -> outputs reset immediately, no rsp after release.

Source files
------------

// File: rtl/ahb_lite_fifo_master.sv
// AHB-Lite master fed from the transaction FIFO.
// Commands popped from the FIFO are issued as pipelined SINGLE transfers
// (address phase -> data phase), and one response is returned per command in
// pop order.
//
// Handshakes:
//   cmd: a command transfers on a rising edge where cmd_valid && cmd_ready;
//        cmd_valid may drop at any time before that edge.
//   rsp: rsp_valid is a single-cycle pulse with no backpressure; the rsp_*
//        fields read 0 whenever rsp_valid is low.
module ahb_lite_fifo_master #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [2:0]           cmd_size,
  input  logic [BUS_WIDTH-1:0] cmd_addr,
  input  logic [BUS_WIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic                 rsp_error,
  output logic [BUS_WIDTH-1:0] rsp_rdata,
  output logic [BUS_WIDTH-1:0] HADDR,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic                 HMASTLOCK,
  output logic [1:0]           HTRANS,
  output logic [BUS_WIDTH-1:0] HWDATA,
  input  logic [BUS_WIDTH-1:0] HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // ERR_WAIT covers the second cycle of a two-cycle ERROR response.
  typedef enum logic {
    ERR_NONE = 1'b0,
    ERR_WAIT = 1'b1
  } err_st_e;

  err_st_e err_st_q, err_st_d;

  // Address-phase slot
  logic                 ap_valid_q, ap_valid_d;
  logic                 ap_write_q, ap_write_d;
  logic [2:0]           ap_size_q,  ap_size_d;
  logic [BUS_WIDTH-1:0] ap_addr_q,  ap_addr_d;
  logic [BUS_WIDTH-1:0] ap_wdata_q, ap_wdata_d;

  // Data-phase slot
  logic                 dp_valid_q, dp_valid_d;
  logic                 dp_write_q, dp_write_d;
  logic [BUS_WIDTH-1:0] hwdata_q,   hwdata_d;

  // Transfer withdrawn from the address phase by an ERROR, still owed a response
  logic                 cancel_pend_q,  cancel_pend_d;
  logic                 cancel_write_q, cancel_write_d;

  // Response registers
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_write_q, rsp_write_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [BUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept;

  // Pop only when the bus can take a new address and no error recovery is pending.
  always_comb begin
    cmd_ready = resetn && HREADY && (err_st_q == ERR_NONE) && !cancel_pend_q;
    accept    = cmd_valid && cmd_ready;
  end

  // Next-state: pipeline advance, error/cancel sequencing and response generation.
  always_comb begin
    err_st_d       = err_st_q;
    ap_valid_d     = ap_valid_q;
    ap_write_d     = ap_write_q;
    ap_size_d      = ap_size_q;
    ap_addr_d      = ap_addr_q;
    ap_wdata_d     = ap_wdata_q;
    dp_valid_d     = dp_valid_q;
    dp_write_d     = dp_write_q;
    hwdata_d       = hwdata_q;
    cancel_pend_d  = cancel_pend_q;
    cancel_write_d = cancel_write_q;
    rsp_valid_d    = 1'b0;
    rsp_write_d    = 1'b0;
    rsp_error_d    = 1'b0;
    rsp_rdata_d    = '0;

    // Responses: a completing data phase, otherwise the owed cancelled transfer.
    if (dp_valid_q && HREADY) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = dp_write_q;
      rsp_error_d = HRESP;
      rsp_rdata_d = (!dp_write_q && !HRESP) ? HRDATA : '0;
    end else if (cancel_pend_q && (err_st_q == ERR_NONE)) begin
      rsp_valid_d   = 1'b1;
      rsp_write_d   = cancel_write_q;
      rsp_error_d   = 1'b1;
      cancel_pend_d = 1'b0;
    end

    case (err_st_q)
      ERR_NONE: begin
        if (HREADY) begin
          dp_valid_d = ap_valid_q;
          dp_write_d = ap_write_q;
          if (ap_valid_q && ap_write_q) begin
            hwdata_d = ap_wdata_q;
          end
          if (accept) begin
            ap_valid_d = 1'b1;
            ap_write_d = cmd_write;
            ap_size_d  = cmd_size;
            ap_addr_d  = cmd_addr;
            ap_wdata_d = cmd_wdata;
          end else begin
            ap_valid_d = 1'b0;
          end
        end else if (dp_valid_q && HRESP) begin
          // First ERROR cycle: withdraw any queued address so the bus idles next cycle.
          err_st_d = ERR_WAIT;
          if (ap_valid_q) begin
            ap_valid_d     = 1'b0;
            cancel_pend_d  = 1'b1;
            cancel_write_d = ap_write_q;
          end
        end
      end
      ERR_WAIT: begin
        if (HREADY) begin
          dp_valid_d = 1'b0;
          err_st_d   = ERR_NONE;
        end
      end
      default: err_st_d = ERR_NONE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_st_q       <= ERR_NONE;
      ap_valid_q     <= 1'b0;
      ap_write_q     <= 1'b0;
      ap_size_q      <= '0;
      ap_addr_q      <= '0;
      ap_wdata_q     <= '0;
      dp_valid_q     <= 1'b0;
      dp_write_q     <= 1'b0;
      hwdata_q       <= '0;
      cancel_pend_q  <= 1'b0;
      cancel_write_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_error_q    <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      err_st_q       <= err_st_d;
      ap_valid_q     <= ap_valid_d;
      ap_write_q     <= ap_write_d;
      ap_size_q      <= ap_size_d;
      ap_addr_q      <= ap_addr_d;
      ap_wdata_q     <= ap_wdata_d;
      dp_valid_q     <= dp_valid_d;
      dp_write_q     <= dp_write_d;
      hwdata_q       <= hwdata_d;
      cancel_pend_q  <= cancel_pend_d;
      cancel_write_q <= cancel_write_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      rsp_error_q    <= rsp_error_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  // Bus and response outputs come straight from registers.
  always_comb begin
    HADDR     = ap_addr_q;
    HWRITE    = ap_write_q;
    HSIZE     = ap_size_q;
    HTRANS    = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    HBURST    = 3'b000;
    HPROT     = 4'b0011;
    HMASTLOCK = 1'b0;
    HWDATA    = hwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_write = rsp_write_q;
    rsp_error = rsp_error_q;
    rsp_rdata = rsp_rdata_q;
  end

endmodule

// File: tb/tb_ahb_lite_fifo_master.sv
// Bench for ahb_lite_fifo_master: an AHB slave model with wait states and
// ERROR responses, a FIFO-side command driver, a response scoreboard fed by a
// transaction-level model, and directed cycle-exact scenarios.
module tb_ahb_lite_fifo_master;

  localparam int W = 32;

  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic         cmd_valid, cmd_ready, cmd_write;
  logic [2:0]   cmd_size;
  logic [W-1:0] cmd_addr, cmd_wdata;
  logic         rsp_valid, rsp_write, rsp_error;
  logic [W-1:0] rsp_rdata;
  logic [W-1:0] HADDR, HWDATA, HRDATA;
  logic         HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]   HSIZE, HBURST;
  logic [3:0]   HPROT;
  logic [1:0]   HTRANS;

  ahb_lite_fifo_master #(.BUS_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_error(rsp_error),
    .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_seen = 0;

  logic [33:0] exp_q[$];     // {write, error, rdata}
  cmd_t        cmd_q[$];     // commands waiting in the "FIFO"
  cmd_t        iss_q[$];     // commands expected to appear on the bus, in order
  int          acc_cyc_q[$]; // cycles whose closing edge accepted a command

  logic [31:0] mmem [64];    // model memory (updated in accept order)
  logic [31:0] smem [64];    // slave memory (updated at write completion)

  // slave data-phase state
  bit   sl_dp_valid;
  cmd_t sl_dp;
  int   sl_wait;
  bit   sl_err_second;
  bit   rand_waits;
  logic [31:0] wait_addr;
  int   wait_n;
  int   valid_pct;
  int   issued_34;

  // model state for cancellation
  int hr_cnt;
  int prev_hr_idx;
  bit prev_slave_err;

  // per-cycle traces
  logic [1:0]  tr_htrans [8192];
  logic [31:0] tr_haddr  [8192];
  logic [31:0] tr_hwdata [8192];
  logic        tr_rdy    [8192];
  logic        tr_rv     [8192];
  logic        tr_rw     [8192];
  logic        tr_re     [8192];
  logic [31:0] tr_rd     [8192];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dflt(input int i);
    return {16'hC0DE, 8'(i), 8'(~i)};
  endfunction

  function automatic bit err_region(input logic [31:0] a);
    return a[7:4] == 4'h3;
  endfunction

  function automatic logic [34:0] tr_rsp(input int c);
    int ix;
    ix = c % 8192;
    return {tr_rv[ix], tr_rw[ix], tr_re[ix], tr_rd[ix]};
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mmem[a[7:2]] = d;
    smem[a[7:2]] = d;
  endtask

  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = wr; c.size = 3'd2; c.addr = a; c.wdata = d;
    cmd_q.push_back(c);
  endtask

  task automatic reset_model();
    exp_q.delete();
    iss_q.delete();
    cmd_q.delete();
    sl_dp_valid    = 0;
    sl_err_second  = 0;
    sl_wait        = 0;
    prev_slave_err = 0;
    prev_hr_idx    = -10;
  endtask

  // Transaction-level model: a command is cancelled exactly when the previous
  // command will get an ERROR from the slave and this one was accepted on the
  // first ready edge after it (so it sat in the address phase behind it).
  task automatic model_accept(input cmd_t c);
    bit canc;
    canc = prev_slave_err && (hr_cnt == prev_hr_idx + 1);
    if (canc) begin
      exp_q.push_back({c.wr, 1'b1, 32'h0});
    end else begin
      iss_q.push_back(c);
      if (err_region(c.addr)) begin
        exp_q.push_back({c.wr, 1'b1, 32'h0});
      end else if (c.wr) begin
        mmem[c.addr[7:2]] = c.wdata;
        exp_q.push_back({1'b1, 1'b0, 32'h0});
      end else begin
        exp_q.push_back({1'b0, 1'b0, mmem[c.addr[7:2]]});
      end
    end
    prev_slave_err = !canc && err_region(c.addr);
    prev_hr_idx    = hr_cnt;
    acc_cyc_q.push_back(cyc);
  endtask

  // ---------------- one bus cycle: trace, slave, driver ----------------
  task automatic step();
    int   ix;
    cmd_t e;
    @(negedge clk);
    cyc++;
    ix = cyc % 8192;
    tr_htrans[ix] = HTRANS;
    tr_haddr[ix]  = HADDR;
    tr_hwdata[ix] = HWDATA;
    tr_rv[ix]     = rsp_valid;
    tr_rw[ix]     = rsp_write;
    tr_re[ix]     = rsp_error;
    tr_rd[ix]     = rsp_rdata;
    check("htrans_legal", {63'h0, HTRANS[0]}, 64'h0);

    // slave: data-phase response for this cycle
    HRDATA = $urandom;
    HRESP  = 1'b0;
    HREADY = 1'b1;
    if (sl_dp_valid) begin
      if (sl_wait > 0) begin
        HREADY = 1'b0;
        sl_wait--;
      end else if (err_region(sl_dp.addr)) begin
        HRESP = 1'b1;
        if (!sl_err_second) begin
          HREADY        = 1'b0;
          sl_err_second = 1;
        end
      end else if (sl_dp.wr) begin
        check("hwdata", HWDATA, sl_dp.wdata);
        smem[sl_dp.addr[7:2]] = HWDATA;
      end else begin
        HRDATA = smem[sl_dp.addr[7:2]];
      end
    end

    // FIFO side
    if (resetn && cmd_q.size() > 0 && ($urandom_range(99) < valid_pct)) begin
      cmd_valid = 1'b1;
      cmd_write = cmd_q[0].wr;
      cmd_size  = cmd_q[0].size;
      cmd_addr  = cmd_q[0].addr;
      cmd_wdata = cmd_q[0].wdata;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_size  = 3'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
    end

    #1;
    tr_rdy[ix] = cmd_ready;
    if (resetn && HREADY) hr_cnt++;
    if (cmd_valid && cmd_ready) model_accept(cmd_q.pop_front());

    // slave: address phase handed to the data phase at the coming edge
    if (resetn && HREADY) begin
      if (HTRANS == 2'b10) begin
        if (HADDR == 32'h34) issued_34++;
        if (iss_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_unexpected: got NONSEQ at 0x%0h, expected no transfer (cycle %0d)", HADDR, cyc);
          e.wr = HWRITE; e.size = HSIZE; e.addr = HADDR; e.wdata = '0;
        end else begin
          e = iss_q.pop_front();
          check("issue", {28'h0, HWRITE, HSIZE, HADDR}, {28'h0, e.wr, e.size, e.addr});
        end
        sl_dp_valid   = 1;
        sl_dp         = e;
        sl_err_second = 0;
        if (rand_waits) sl_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        else            sl_wait = (e.addr == wait_addr) ? wait_n : 0;
      end else begin
        sl_dp_valid = 0;
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || cmd_q.size() != 0) && budget < 20000) begin
      step();
      budget++;
    end
    check("drain_pending", exp_q.size() + cmd_q.size(), 0);
    repeat (3) step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp w=%0b e=%0b d=0x%0h, expected no response", rsp_write, rsp_error, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp", {30'h0, rsp_write, rsp_error, rsp_rdata}, {30'h0, e});
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int a;
    int c0;
    int snap;
    cmd_t rc;

    for (int i = 0; i < 64; i++) begin
      mmem[i] = dflt(i);
      smem[i] = dflt(i);
    end
    resetn     = 1'b0;
    cmd_valid  = 1'b0; cmd_write = 1'b0; cmd_size = 3'd0; cmd_addr = '0; cmd_wdata = '0;
    HREADY     = 1'b1; HRESP = 1'b0; HRDATA = '0;
    rand_waits = 0; wait_addr = 32'hFFFF_FFFF; wait_n = 0; valid_pct = 100;
    issued_34  = 0; hr_cnt = 0;
    reset_model();

    // 1: reset values, ready after release
    repeat (3) step();
    check("reset_htrans", HTRANS, 2'b00);
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_haddr", HADDR, 32'h0);
    check("reset_hwdata", HWDATA, 32'h0);
    check("hburst", HBURST, 3'b000);
    check("hprot", HPROT, 4'b0011);
    check("hmastlock", HMASTLOCK, 1'b0);
    resetn = 1'b1;
    #1;
    check("release_cmd_ready", cmd_ready, 1'b1);

    // 2: back-to-back W/R/W
    acc_cyc_q.delete();
    preload(32'h14, 32'h55);
    push_cmd(1'b1, 32'h10, 32'hAA);
    push_cmd(1'b0, 32'h14, 32'h0);
    push_cmd(1'b1, 32'h18, 32'hCC);
    repeat (8) step();
    a = acc_cyc_q[0];
    check("b2b_accepts", acc_cyc_q.size(), 3);
    check("b2b_accept_gap", acc_cyc_q[2] - a, 2);
    for (int k = 0; k < 3; k++) begin
      check("b2b_htrans", tr_htrans[(a + 1 + k) % 8192], 2'b10);
      check("b2b_haddr", tr_haddr[(a + 1 + k) % 8192], 32'h10 + 32'(4 * k));
    end
    check("b2b_hwdata0", tr_hwdata[(a + 2) % 8192], 32'hAA);
    check("b2b_hwdata2", tr_hwdata[(a + 4) % 8192], 32'hCC);
    check("b2b_rsp0", tr_rsp(a + 3), {1'b1, 1'b1, 1'b0, 32'h0});
    check("b2b_rsp1", tr_rsp(a + 4), {1'b1, 1'b0, 1'b0, 32'h55});
    check("b2b_rsp2", tr_rsp(a + 5), {1'b1, 1'b1, 1'b0, 32'h0});
    drain();

    // 3: wait states on a read
    acc_cyc_q.delete();
    preload(32'h20, 32'h1234_5678);
    wait_addr = 32'h20; wait_n = 2;
    push_cmd(1'b0, 32'h20, 32'h0);
    push_cmd(1'b0, 32'h24, 32'h0);
    push_cmd(1'b0, 32'h28, 32'h0);
    repeat (10) step();
    a = acc_cyc_q[0];
    check("wait_haddr_a2", tr_haddr[(a + 2) % 8192], 32'h24);
    check("wait_haddr_a3", tr_haddr[(a + 3) % 8192], 32'h24);
    check("wait_htrans_a3", tr_htrans[(a + 3) % 8192], 2'b10);
    check("wait_haddr_a4", tr_haddr[(a + 4) % 8192], 32'h24);
    check("wait_rdy_a2", tr_rdy[(a + 2) % 8192], 1'b0);
    check("wait_rdy_a3", tr_rdy[(a + 3) % 8192], 1'b0);
    check("wait_no_early_rsp", tr_rv[(a + 4) % 8192], 1'b0);
    check("wait_rsp", tr_rsp(a + 5), {1'b1, 1'b0, 1'b0, 32'h1234_5678});
    wait_addr = 32'hFFFF_FFFF;
    drain();

    // 4: ERROR on a write cancels the queued read
    acc_cyc_q.delete();
    issued_34 = 0;
    push_cmd(1'b1, 32'h30, 32'hDEAD_BEEF);
    push_cmd(1'b0, 32'h34, 32'h0);
    push_cmd(1'b0, 32'h44, 32'h0);
    repeat (10) step();
    a = acc_cyc_q[0];
    check("err_accept1", acc_cyc_q[1] - a, 1);
    check("err_haddr_a1", tr_haddr[(a + 1) % 8192], 32'h30);
    check("err_haddr_a2", tr_haddr[(a + 2) % 8192], 32'h34);
    check("err_idle_a3", tr_htrans[(a + 3) % 8192], 2'b00);
    check("err_rdy_a3", tr_rdy[(a + 3) % 8192], 1'b0);
    check("err_rdy_a4", tr_rdy[(a + 4) % 8192], 1'b0);
    check("err_rsp_w", tr_rsp(a + 4), {1'b1, 1'b1, 1'b1, 32'h0});
    check("err_rsp_r", tr_rsp(a + 5), {1'b1, 1'b0, 1'b1, 32'h0});
    check("err_accept_after", acc_cyc_q[2] - a, 5);
    check("err_never_issued", issued_34, 0);
    drain();

    // 5: empty FIFO
    c0 = cyc;
    repeat (6) step();
    for (int c = c0 + 1; c <= c0 + 6; c++) begin
      check("empty_idle", tr_htrans[c % 8192], 2'b00);
      check("empty_no_rsp", tr_rv[c % 8192], 1'b0);
    end

    // 6: asynchronous reset during a waited read
    acc_cyc_q.delete();
    wait_addr = 32'h40; wait_n = 5;
    push_cmd(1'b0, 32'h40, 32'h0);
    repeat (4) step();
    check("arst_in_dp", tr_haddr[cyc % 8192], 32'h40);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_htrans", HTRANS, 2'b00);
    check("arst_haddr", HADDR, 32'h0);
    check("arst_hwdata", HWDATA, 32'h0);
    check("arst_cmd_ready", cmd_ready, 1'b0);
    reset_model();
    snap = rsp_seen;
    repeat (3) step();
    resetn = 1'b1;
    repeat (8) step();
    check("arst_no_rsp", rsp_seen - snap, 0);
    wait_addr = 32'hFFFF_FFFF;

    // random traffic with wait states, errors and FIFO bubbles
    rand_waits = 1;
    valid_pct  = 70;
    for (int i = 0; i < 400; i++) begin
      rc.wr    = 1'($urandom);
      rc.size  = 3'($urandom_range(0, 2));
      rc.addr  = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
      rc.wdata = $urandom;
      cmd_q.push_back(rc);
    end
    drain();
    check("iss_leftover", iss_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
